fc1_bias_sink: RTL and testbench

FC1_BIAS_SINK -- requirements
Module: fc1_bias_sink

---
 rtl/fc1_bias_sink_if.sv | 22 ++
 rtl/fc1_bias_sink.sv | 152 +++++++++++++++
 tb/tb_fc1_bias_sink.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fc1_bias_sink_if.sv
// Bias beat stream into the fc1 bias sink.
// Source drives data/valid, sink returns ready.
interface fc1_bias_sink_if #(
    parameter int PREC = 16,
    parameter int N    = 1
);
    logic [PREC-1:0] data_in [N];
    logic            data_in_valid;
    logic            data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/fc1_bias_sink.sv
// Captures one bias tensor beat-by-beat into a local memory
// and serves it through a two-stage registered read port.
module fc1_bias_sink #(
    parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int BIAS_PARALLELISM_DIM_0 = 1,
    parameter int BIAS_PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH =
        (BIAS_TENSOR_SIZE_DIM_0 * BIAS_TENSOR_SIZE_DIM_1) /
        (BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1),
    parameter int ADDR_WIDTH = $clog2(IN_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    fc1_bias_sink_if.slave        in_if,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic                  ce0,
    output logic [BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0-1:0] q0,
    output logic                  loaded,
    output logic [ADDR_WIDTH-1:0] count
);

    localparam int NPAR   = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;
    localparam int W_WORD = BIAS_PRECISION_0 * NPAR;
    localparam int W_Q    = BIAS_PRECISION_0 * BIAS_PARALLELISM_DIM_0;
    localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(IN_DEPTH);

    // Fractional width only travels with the data; reject nonsense configs.
    if (BIAS_PRECISION_1 > BIAS_PRECISION_0) begin : g_bad_frac
        $error("fc1_bias_sink: fractional bits exceed element width");
    end
    if (IN_DEPTH < 1) begin : g_bad_depth
        $error("fc1_bias_sink: tensor smaller than one beat");
    end

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  loaded_q, loaded_d;
    logic                  ready;
    logic                  wr_en;

    logic [W_WORD-1:0]     mem [IN_DEPTH];
    logic [W_WORD-1:0]     wr_word;
    logic [W_WORD-1:0]     rd_word;
    logic [W_Q-1:0]        stage0_q;
    logic [W_Q-1:0]        stage1_q;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            loaded_q <= loaded_d;
        end
    end

    // Clear wins over a same-cycle beat by forcing ready low.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        loaded_d = loaded_q;
        ready    = 1'b0;
        wr_en    = 1'b0;
        if (clear) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    ready = 1'b1;
                    if (in_if.data_in_valid) begin
                        wr_en = 1'b1;
                        if (wr_ptr_q == LAST) begin
                            state_d  = HOLD;
                            wr_ptr_d = '0;
                            count_d  = FULL;
                            loaded_d = 1'b1;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    ready = 1'b0;
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    always_comb begin
        wr_word = '0;
        for (int j = 0; j < NPAR; j++) begin
            wr_word[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = in_if.data_in[j];
        end
    end

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = address0[IDX_W-1:0];
    assign rd_hit = (address0 < FULL);

    // Storage is never reset; reads see pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
    end

    assign rd_word = rd_hit ? mem[rd_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage0_q <= '0;
            stage1_q <= '0;
        end else if (ce0) begin
            stage0_q <= rd_word[W_Q-1:0];
            stage1_q <= stage0_q;
        end
    end

    assign in_if.data_in_ready = ready;
    assign q0                  = stage1_q;
    assign loaded              = loaded_q;
    assign count               = count_q;

endmodule

// File: tb/tb_fc1_bias_sink.sv
// Directed bench for fc1_bias_sink with a per-cycle reference model.
module tb_fc1_bias_sink;

    localparam int DEPTH = 32;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [AW-1:0] address0 = '0;
    logic          ce0 = 1'b0;
    logic [15:0]   q0;
    logic          loaded;
    logic [AW-1:0] count;

    int checks = 0;
    int errors = 0;

    fc1_bias_sink_if #(.PREC(16), .N(1)) bus ();

    fc1_bias_sink dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (bus.slave),
        .clear    (clear),
        .address0 (address0),
        .ce0      (ce0),
        .q0       (q0),
        .loaded   (loaded),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Reference: count doubles as write address; loaded once DEPTH taken.
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_count  = 0;
    bit          m_loaded = 1'b0;
    logic [15:0] p0 = '0, p1 = '0;
    bit          p0k = 1'b1, p1k = 1'b1;
    logic [15:0] rdv;
    bit          rdk;
    int          ai;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
    end

    always @(negedge rst) begin
        m_count  = 0;
        m_loaded = 1'b0;
        p0 = '0; p1 = '0;
        p0k = 1'b1; p1k = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            ai  = int'(address0);
            rdv = (ai < DEPTH) ? m_mem[ai] : 16'h0;
            rdk = (ai >= DEPTH) || m_known[ai];
            if (ce0) begin
                p1 = p0; p1k = p0k;
                p0 = rdv; p0k = rdk;
            end
            if (clear) begin
                m_count  = 0;
                m_loaded = 1'b0;
            end else if (!m_loaded && bus.data_in_valid) begin
                m_mem[m_count]   = bus.data_in[0];
                m_known[m_count] = 1'b1;
                m_count++;
                if (m_count == DEPTH) m_loaded = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(m_count));
        chk("m_loaded", 32'(loaded), 32'(m_loaded));
        chk("m_ready", 32'(bus.data_in_ready), 32'(!m_loaded && !clear));
        if (p1k) chk("m_q0", 32'(q0), 32'(p1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [15:0] base, input int n,
                          input bit gaps, output int rdy);
        rdy = 0;
        for (int i = 0; i < n; i++) begin
            bus.data_in_valid = 1'b1;
            bus.data_in[0]    = base + 16'(i);
            #1;
            if (bus.data_in_ready) rdy++;
            step();
            if (gaps) begin
                bus.data_in_valid = 1'b0;
                step();
                chk("bp_count", 32'(count), 32'(i + 1));
            end
        end
        bus.data_in_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [15:0] exp,
                      input string nm);
        address0 = a;
        ce0      = 1'b1;
        step();
        step();
        chk(nm, 32'(q0), 32'(exp));
        ce0 = 1'b0;
    endtask

    int rdy;

    initial begin
        bus.data_in_valid = 1'b0;
        bus.data_in[0]    = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_q0", 32'(q0), 32'd0);
        repeat (2) step();
        rst = 1'b1;

        stream(16'h0100, DEPTH, 1'b0, rdy);
        chk("cont_ready_cycles", 32'(rdy), 32'd32);
        bus.data_in_valid = 1'b1;
        bus.data_in[0]    = 16'hBEEF;
        step();
        bus.data_in_valid = 1'b0;
        chk("cont_loaded", 32'(loaded), 32'd1);
        chk("cont_count", 32'(count), 32'd32);
        chk("cont_ready", 32'(bus.data_in_ready), 32'd0);

        rd(6'd5, 16'h0105, "rd_5");
        rd(6'd40, 16'h0000, "rd_40");
        rd(6'd31, 16'h011F, "rd_31");
        rd(6'd32, 16'h0000, "rd_32");
        rd(6'd0, 16'h0100, "hold_no_overwrite");

        rd(6'd7, 16'h0107, "rd_7");
        address0 = 6'd9;
        ce0      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ce0_hold", 32'(q0), 32'h0107);
        end
        ce0 = 1'b1;
        step();
        chk("ce0_resume1", 32'(q0), 32'h0107);
        step();
        chk("ce0_resume2", 32'(q0), 32'h0109);
        ce0 = 1'b0;

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        stream(16'h0100, DEPTH, 1'b1, rdy);
        chk("bp_loaded", 32'(loaded), 32'd1);
        rd(6'd12, 16'h010C, "bp_rd_12");

        clear = 1'b1;
        step();
        clear = 1'b0;
        stream(16'h0300, 10, 1'b0, rdy);
        bus.data_in_valid = 1'b1;
        bus.data_in[0]    = 16'hDEAD;
        clear             = 1'b1;
        #1;
        chk("clr_ready", 32'(bus.data_in_ready), 32'd0);
        step();
        clear             = 1'b0;
        bus.data_in_valid = 1'b0;
        chk("clr_count2", 32'(count), 32'd0);
        rd(6'd10, 16'h010A, "clr_beat_dropped");
        rd(6'd9, 16'h0309, "clr_partial");
        stream(16'h0200, DEPTH, 1'b0, rdy);
        rd(6'd3, 16'h0203, "reload_rd_3");

        clear = 1'b1;
        step();
        clear = 1'b0;
        stream(16'h0400, 17, 1'b0, rdy);
        chk("pre_rst_count", 32'(count), 32'd17);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_loaded", 32'(loaded), 32'd0);
        chk("arst_q0", 32'(q0), 32'd0);
        step();
        rst = 1'b1;
        stream(16'h0500, DEPTH, 1'b0, rdy);
        chk("arst_reload_ready", 32'(rdy), 32'd32);
        rd(6'd0, 16'h0500, "arst_rd_0");
        rd(6'd31, 16'h051F, "arst_rd_31");

        step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
